screen_ram_arbiter: RTL

- Shares the single-port framebuffer RAM between the VGA pixel fetch path and the CPU.
- Framebuffer geometry: 32-bit words, 8 pixels × 4-bit colour index per word, 488×280 window, so 17080 words.
- The display normally wins arbitration. An aging counter guarantees the CPU a slot within a bounded wait.
- Sits between the display word-address generator, the CPU store/load bus and the framebuffer RAM (synchronous read, 1-cycle latency).

---
 rtl/screen_ram_arbiter_if.sv | 48 ++++
 rtl/screen_ram_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/screen_ram_arbiter_if.sv
// Bus bundle for screen_ram_arbiter.
// Groups the three sides of the arbiter:
//   display fetch : disp_req, disp_addr -> disp_data, disp_valid
//   CPU bus       : cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask -> cpu_ack, cpu_rdata
//   RAM port      : ram_en, ram_we, ram_addr, ram_wdata -> ram_rdata
// modport slave  : the arbiter's view.
// modport master : the surrounding environment (display, CPU and RAM).
interface screen_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32
);
    logic                  disp_req;
    logic [ADDR_WIDTH-1:0] disp_addr;
    logic [DATA_WIDTH-1:0] disp_data;
    logic                  disp_valid;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [3:0]            cpu_wmask;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        input  ram_rdata,
        output disp_data, disp_valid,
        output cpu_ack, cpu_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output disp_req, disp_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        output ram_rdata,
        input  disp_data, disp_valid,
        input  cpu_ack, cpu_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/screen_ram_arbiter.sv
// screen_ram_arbiter
// Shares the single-port framebuffer RAM between the VGA word fetch and the CPU.
// The display normally wins; an aging counter lets the CPU win after
// CPU_MAX_WAIT lost arbitrations. Each service is IDLE -> ACCESS -> DATA and
// the completion pulse (disp_valid / cpu_ack) appears in the following IDLE
// cycle, where a new grant can already be made.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : screen_ram_arbiter_if.slave (display, CPU and RAM sides)
module screen_ram_arbiter #(
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 32,
    parameter int FB_WORDS     = 17080,
    parameter int CPU_MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    screen_ram_arbiter_if.slave bus
);
    localparam int AGE_BITS = ($clog2(CPU_MAX_WAIT + 1) < 4) ? 4 : $clog2(CPU_MAX_WAIT + 1);
    localparam logic [AGE_BITS-1:0]   AGE_MAX  = AGE_BITS'(CPU_MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] FB_LIMIT = ADDR_WIDTH'(FB_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t                state_reg, state_next;

    logic                  disp_pend_reg;
    logic [ADDR_WIDTH-1:0] pend_addr_reg;
    logic [AGE_BITS-1:0]   age_reg;

    // what is being serviced
    logic                  svc_cpu_reg;
    logic                  svc_we_reg;
    logic                  svc_oor_reg;

    logic [DATA_WIDTH-1:0] disp_data_reg;
    logic                  disp_valid_reg;
    logic                  cpu_ack_reg;
    logic [DATA_WIDTH-1:0] cpu_rdata_reg;
    logic                  ram_en_reg;
    logic [3:0]            ram_we_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic [DATA_WIDTH-1:0] ram_wdata_reg;

    logic                  cpu_live;
    logic                  disp_want;
    logic                  grant_cpu;
    logic                  grant_disp;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  grant_oor;

    // The CPU keeps cpu_req high during its ack cycle; masking with the ack
    // stops the same request from being granted twice.
    assign cpu_live  = bus.cpu_req & ~cpu_ack_reg;
    // A pulse arriving while idle counts as a display request straight away,
    // so a simultaneous CPU request loses unless it has aged out.
    assign disp_want = disp_pend_reg | bus.disp_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_cpu  = 1'b0;
        grant_disp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_live && (!disp_want || age_reg >= AGE_MAX)) begin
                    grant_cpu = 1'b1;
                end else if (disp_want) begin
                    grant_disp = 1'b1;
                end
                if (grant_cpu || grant_disp) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = DATA;
            DATA:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An already-pending address is served before a pulse arriving this cycle;
    // that pulse then stays pending.
    always_comb begin
        grant_addr = bus.disp_addr;
        if (grant_cpu) begin
            grant_addr = bus.cpu_addr;
        end else if (disp_pend_reg) begin
            grant_addr = pend_addr_reg;
        end
    end

    assign grant_oor = (grant_addr >= FB_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_pend_reg  <= 1'b0;
            pend_addr_reg  <= '0;
            age_reg        <= '0;
            svc_cpu_reg    <= 1'b0;
            svc_we_reg     <= 1'b0;
            svc_oor_reg    <= 1'b0;
            disp_data_reg  <= '0;
            disp_valid_reg <= 1'b0;
            cpu_ack_reg    <= 1'b0;
            cpu_rdata_reg  <= '0;
            ram_en_reg     <= 1'b0;
            ram_we_reg     <= '0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
        end else begin
            disp_valid_reg <= 1'b0;
            cpu_ack_reg    <= 1'b0;

            // Pending latch: latest pulse wins. If the pending word is being
            // granted now, only a fresh pulse keeps the latch set.
            if (bus.disp_req) begin
                pend_addr_reg <= bus.disp_addr;
            end
            if (grant_disp) begin
                disp_pend_reg <= disp_pend_reg & bus.disp_req;
            end else if (bus.disp_req) begin
                disp_pend_reg <= 1'b1;
            end

            if (!cpu_live || grant_cpu) begin
                age_reg <= '0;
            end else if (grant_disp && age_reg < AGE_MAX) begin
                age_reg <= age_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (grant_cpu || grant_disp) begin
                        svc_cpu_reg  <= grant_cpu;
                        svc_we_reg   <= grant_cpu & bus.cpu_we;
                        svc_oor_reg  <= grant_oor;
                        // Out-of-range accesses keep their timing slot but never touch the RAM.
                        ram_en_reg   <= ~grant_oor;
                        ram_we_reg   <= (grant_cpu && bus.cpu_we && !grant_oor) ? bus.cpu_wmask : 4'b0000;
                        ram_addr_reg <= grant_addr;
                        if (grant_cpu && bus.cpu_we) begin
                            ram_wdata_reg <= bus.cpu_wdata;
                        end
                    end
                end
                ACCESS: begin
                    ram_en_reg <= 1'b0;
                    ram_we_reg <= 4'b0000;
                end
                DATA: begin
                    if (svc_cpu_reg) begin
                        cpu_ack_reg <= 1'b1;
                        if (!svc_we_reg) begin
                            cpu_rdata_reg <= svc_oor_reg ? '0 : bus.ram_rdata;
                        end
                    end else begin
                        disp_valid_reg <= 1'b1;
                        disp_data_reg  <= svc_oor_reg ? '0 : bus.ram_rdata;
                    end
                end
                default: begin
                    ram_en_reg <= 1'b0;
                    ram_we_reg <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.disp_data  = disp_data_reg;
    assign bus.disp_valid = disp_valid_reg;
    assign bus.cpu_ack    = cpu_ack_reg;
    assign bus.cpu_rdata  = cpu_rdata_reg;
    assign bus.ram_en     = ram_en_reg;
    assign bus.ram_we     = ram_we_reg;
    assign bus.ram_addr   = ram_addr_reg;
    assign bus.ram_wdata  = ram_wdata_reg;
endmodule
